av_palette_mapper: RTL
======================

Name: av_palette_mapper

Overview:
- Parametrised palette block for the Adventure Vision video path.
- Takes an IDX_W-bit LED intensity index plus sync/blank/ce from av_video and produces blanked 24-bit RGB after a fixed pipeline delay.
- Colours come from an N-entry palette loaded byte-wise from the HPS download stream into a shadow bank, then committed to the active bank at the next vertical blank, so a frame never shows a partly loaded palette.
- When the palette is disabled, it outputs the monochrome red-LED rendering.

Parameters:
- IDX_W, 3, width of the intensity index; NUM_ENTRIES = 2**IDX_W.
- PIPE_DEPTH, 4, total video latency in cycles; legal range 2..8.

Ports:
- clk_i  in  1  video clock; the only clock.
- reset_n_i  in  1  asynchronous active-low reset.
- load_active_i  in  1  palette download in progress (level).
- load_wr_i  in  1  byte strobe, valid only while load_active_i=1.
- load_data_i  in  8  download byte.
- use_pal_i  in  1  1 = palette lookup, 0 = monochrome red.
- idx_i  in  IDX_W  pixel intensity index.
- ce_pix_i, hsync_i, vsync_i, hblank_i, vblank_i  in  1 each  video timing in.
- rgb_o  out  24  {R,G,B}.
- ce_pix_o, hsync_o, vsync_o, hblank_o, vblank_o  out  1 each  timing, delayed PIPE_DEPTH.
- load_busy_o  out  1  download in progress.
- commit_pending_o  out  1  shadow waiting for vblank.
- overflow_o  out  1  sticky: more than 3*NUM_ENTRIES bytes received in the last download.

Behaviour:
- Reset values:
  - All outputs 0; byte counter 0.
  - Both banks hold the default palette: entry i = grey level g(i) on all three channels.
  - g(i) = IDX_W-bit index bit-replicated MSB-first to 8 bits. For IDX_W=3, i=5 gives 8'hB6.
- Reset mid-download discards all state and restores the defaults.
- Load:
  - A rising edge of load_active_i clears the byte counter, overflow_o and any pending commit; the pending commit is cancelled and not executed.
  - Each load_wr_i writes one byte into the shadow bank at entry = cnt/3, channel = cnt%3 (0=R, 1=G, 2=B), then cnt increments.
  - When cnt reaches 3*NUM_ENTRIES, further bytes are dropped, overflow_o is set, and cnt saturates.
  - Channel and entry are tracked as separate counters (mod-3 and entry); no divider.
- Commit:
  - On the falling edge of load_active_i, commit_pending_o is set if cnt >= 3.
  - The commit copies only the completed entries (floor(cnt/3)); a trailing partial entry is ignored and the active values for those entries stay.
  - With cnt < 3, no commit happens.
  - The commit executes on the first cycle where vblank_i rises (0→1), in a single cycle, and clears commit_pending_o.
  - If vblank_i is already high at the falling edge, the commit waits for the next rising edge.
  - Entries not written keep their previous active values.
- Video pipeline:
  - Stage 0 registers all inputs.
  - Stage 1 performs the lookup (registered).
  - The remaining PIPE_DEPTH-2 stages are plain delay.
  - Colour selection with use_pal_i=1: active[idx].
  - Colour selection with use_pal_i=0: {g(idx), 8'h00, 8'h00}.
  - use_pal_i is sampled in stage 0 together with idx_i.
  - rgb_o is forced to 0 when the delayed hblank or vblank is 1.
  - All timing outputs equal their inputs delayed by exactly PIPE_DEPTH cycles.
  - The pipeline advances every clock, independent of ce_pix.
- A commit in the same cycle as a lookup: the lookup uses the pre-commit active value; the new value is visible from the next cycle.

Decomposition:
- Shared package av_pkg holds:
  - typedef rgb_t (packed R, G, B bytes);
  - typedef vid_timing_t (ce_pix, hsync, vsync, hblank, vblank);
  - constant BYTES_PER_ENTRY=3;
  - function rep8(idx), the bit replicator.
- One sub-module, av_vid_delay: parametrised PIPE_DEPTH-stage shift of vid_timing_t, reused for the timing lanes.

Test Plan:
- Reset with use_pal_i=1, idx=5, blanks 0 -> after 4 cycles rgb_o=24'hB6B6B6; idx=7 -> 24'hFFFFFF.
- Load 24 bytes setting entry 7=24'h828214 and entry 0=24'h5F1A3B, then drop load_active:
  - commit_pending_o=1 and the old colours persist until vblank rises;
  - the next cycle after the rise returns the new colours and commit_pending_o=0.
- Load 7 bytes -> entries 0 and 1 updated, entry 2 unchanged. Load 30 bytes -> overflow_o=1 and all 8 entries updated from the first 24 bytes.
- Start a second download while a commit is pending, then reset_n_i low mid-download:
  - the first commit never appears;
  - after reset the palette is the defaults.
- use_pal_i=0, idx=3 -> rgb_o=24'h6D0000. hblank_i=1 at input -> rgb_o=0 exactly PIPE_DEPTH cycles later.
- PIPE_DEPTH=2 and 8 builds -> hsync/vsync/ce pulses re-appear at exactly 2 and 8 cycles respectively.

Source files
------------

// File: rtl/av_pkg.sv
// Shared types and helpers for the Adventure Vision video path.
package av_pkg;

    localparam int BYTES_PER_ENTRY = 3;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    typedef struct packed {
        logic ce_pix;
        logic hsync;
        logic vsync;
        logic hblank;
        logic vblank;
    } vid_timing_t;

    // Repeat the low w bits of idx, MSB first, until a full byte is filled.
    function automatic logic [7:0] rep8(input logic [7:0] idx, input int w);
        logic [7:0] res;
        res = '0;
        for (int k = 0; k < 8; k++) begin
            res[3'(7 - k)] = idx[3'(w - 1 - (k % w))];
        end
        return res;
    endfunction

endpackage

// File: rtl/av_vid_delay.sv
// Fixed-length shift register for the video timing lanes.
module av_vid_delay
    import av_pkg::*;
#(
    parameter int PIPE_DEPTH = 4
) (
    input  logic                           clk_i,
    input  logic                           reset_n_i,
    input  logic [$bits(vid_timing_t)-1:0] tim_i,
    output logic [$bits(vid_timing_t)-1:0] tim_o
);

    vid_timing_t sr_q [PIPE_DEPTH];

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            for (int k = 0; k < PIPE_DEPTH; k++) begin
                sr_q[k] <= '0;
            end
        end else begin
            sr_q[0] <= vid_timing_t'(tim_i);
            for (int k = 1; k < PIPE_DEPTH; k++) begin
                sr_q[k] <= sr_q[k-1];
            end
        end
    end

    assign tim_o = sr_q[PIPE_DEPTH-1];

endmodule

// File: rtl/av_palette_mapper.sv
// Maps LED intensity indices to blanked RGB through a double-buffered palette
// that is reloaded byte-wise from the download stream and swapped in at vblank.
module av_palette_mapper
    import av_pkg::*;
#(
    parameter int IDX_W      = 3,
    parameter int PIPE_DEPTH = 4
) (
    input  logic             clk_i,
    input  logic             reset_n_i,
    input  logic             load_active_i,
    input  logic             load_wr_i,
    input  logic [7:0]       load_data_i,
    input  logic             use_pal_i,
    input  logic [IDX_W-1:0] idx_i,
    input  logic             ce_pix_i,
    input  logic             hsync_i,
    input  logic             vsync_i,
    input  logic             hblank_i,
    input  logic             vblank_i,
    output logic [23:0]      rgb_o,
    output logic             ce_pix_o,
    output logic             hsync_o,
    output logic             vsync_o,
    output logic             hblank_o,
    output logic             vblank_o,
    output logic             load_busy_o,
    output logic             commit_pending_o,
    output logic             overflow_o
);

    localparam int NUM_ENTRIES = 2 ** IDX_W;
    localparam int ENT_W       = IDX_W + 1;

    function automatic rgb_t grey(input int e);
        logic [7:0] g;
        g = rep8(8'(e), IDX_W);
        return {g, g, g};
    endfunction

    rgb_t             shadow_q [NUM_ENTRIES];
    rgb_t             active_q [NUM_ENTRIES];
    logic             load_act_q, vblank_q;
    logic [1:0]       ch_q, ch_d, wr_ch;
    logic [ENT_W-1:0] ent_q, ent_d;
    logic             ovf_q, ovf_d, pend_q, pend_d;
    logic             wr_en, load_rise, load_fall, commit_en;
    logic [IDX_W-1:0] wr_ent;

    assign load_rise = load_active_i & ~load_act_q;
    assign load_fall = ~load_active_i & load_act_q;
    // A new download cancels a pending commit even if vblank rises the same cycle.
    assign commit_en = pend_q & vblank_i & ~vblank_q & ~load_rise;

    always_comb begin
        ch_d   = ch_q;
        ent_d  = ent_q;
        ovf_d  = ovf_q;
        pend_d = pend_q;
        wr_en  = 1'b0;
        wr_ent = '0;
        wr_ch  = '0;
        if (load_rise) begin
            ch_d   = '0;
            ent_d  = '0;
            ovf_d  = 1'b0;
            pend_d = 1'b0;
        end
        wr_ent = ent_d[IDX_W-1:0];
        wr_ch  = ch_d;
        if (load_active_i && load_wr_i) begin
            if (ent_d == ENT_W'(NUM_ENTRIES)) begin
                ovf_d = 1'b1;
            end else begin
                wr_en = 1'b1;
                if (ch_d == 2'(BYTES_PER_ENTRY - 1)) begin
                    ch_d  = '0;
                    ent_d = ent_d + ENT_W'(1);
                end else begin
                    ch_d = ch_d + 2'd1;
                end
            end
        end
        if (commit_en) pend_d = 1'b0;
        if (load_fall && ent_q != '0) pend_d = 1'b1;
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            for (int e = 0; e < NUM_ENTRIES; e++) begin
                shadow_q[e] <= grey(e);
                active_q[e] <= grey(e);
            end
            load_act_q <= 1'b0;
            vblank_q   <= 1'b0;
            ch_q       <= '0;
            ent_q      <= '0;
            ovf_q      <= 1'b0;
            pend_q     <= 1'b0;
        end else begin
            load_act_q <= load_active_i;
            vblank_q   <= vblank_i;
            ch_q       <= ch_d;
            ent_q      <= ent_d;
            ovf_q      <= ovf_d;
            pend_q     <= pend_d;
            if (wr_en) begin
                case (wr_ch)
                    2'd0:    shadow_q[wr_ent].r <= load_data_i;
                    2'd1:    shadow_q[wr_ent].g <= load_data_i;
                    default: shadow_q[wr_ent].b <= load_data_i;
                endcase
            end
            // Only fully received entries move; a trailing partial entry is dropped.
            if (commit_en) begin
                for (int e = 0; e < NUM_ENTRIES; e++) begin
                    if (ENT_W'(e) < ent_q) active_q[e] <= shadow_q[e];
                end
            end
        end
    end

    logic [IDX_W-1:0] idx_p0_q;
    logic             use_pal_p0_q;
    rgb_t             lookup_d;
    rgb_t             rgb_q [1:PIPE_DEPTH-1];

    always_comb begin
        lookup_d = {rep8(8'(idx_p0_q), IDX_W), 16'h0000};
        if (use_pal_p0_q) lookup_d = active_q[idx_p0_q];
    end

    // Stage 0 captures the pixel, stage 1 holds the lookup, the rest only delay.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            idx_p0_q     <= '0;
            use_pal_p0_q <= 1'b0;
            for (int k = 1; k < PIPE_DEPTH; k++) begin
                rgb_q[k] <= '0;
            end
        end else begin
            idx_p0_q     <= idx_i;
            use_pal_p0_q <= use_pal_i;
            rgb_q[1]     <= lookup_d;
            for (int k = 2; k < PIPE_DEPTH; k++) begin
                rgb_q[k] <= rgb_q[k-1];
            end
        end
    end

    logic [4:0] tim_in, tim_out;
    assign tim_in = {ce_pix_i, hsync_i, vsync_i, hblank_i, vblank_i};

    av_vid_delay #(.PIPE_DEPTH(PIPE_DEPTH)) u_tim_delay (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .tim_i     (tim_in),
        .tim_o     (tim_out)
    );

    assign {ce_pix_o, hsync_o, vsync_o, hblank_o, vblank_o} = tim_out;
    assign rgb_o            = (hblank_o | vblank_o) ? 24'h000000 : rgb_q[PIPE_DEPTH-1];
    assign load_busy_o      = load_act_q;
    assign commit_pending_o = pend_q;
    assign overflow_o       = ovf_q;

endmodule
